// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of control_single. Owns the PC, fetches
// words from instruction memory, keeps up to two fetched words (slot0 is the
// presented instruction, slot1 a prefetched one) and hands one instruction at a
// time downstream through a valid/ready handshake. Branch/jump results for the
// presented instruction redirect the PC; wrong-path words are squashed.
//
// Configuration macro: BRANCH_DELAY_SLOT_EN
//   defined   : a redirecting instruction is followed by its sequential word
//               (delay slot); the redirect is applied when that word is accepted.
//   undefined : the redirect is applied when the branch/jump itself is accepted.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_req/imem_addr  fetch request and word address, held until imem_ack
//   imem_ack/imem_rdata transfer completion and returned instruction word
//   instr/opcode/pc_out presented instruction, its opcode field and its PC
//   instr_valid/ready   downstream handshake
//   branch/bne/zero/jump control results for the presented instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        bne,
    input  logic        zero,
    input  logic        jump
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetchPc_q, fetchPc_d;
    logic [31:0] slot0_q, slot0_d;
    logic [31:0] pc0_q, pc0_d;
    logic [31:0] slot1_q, slot1_d;
    logic        slot1Valid_q, slot1Valid_d;
    logic [31:0] drainTgt_q, drainTgt_d;
`ifdef BRANCH_DELAY_SLOT_EN
    logic        pendValid_q, pendValid_d;
    logic [31:0] pendTgt_q, pendTgt_d;
`endif

    logic        reqRaw;
    logic        xfer;
    logic        accept;
    logic [31:0] pcPlus4;
    logic [31:0] brTgt;
    logic [31:0] jTgt;
    logic        ownRedirect;
    logic [31:0] ownTarget;
    logic        redirect;
    logic [31:0] target;

    // Target of the presented instruction; jump wins over a taken branch.
    assign pcPlus4     = pc0_q + 32'd4;
    assign brTgt       = pcPlus4 + {{14{slot0_q[15]}}, slot0_q[15:0], 2'b00};
    assign jTgt        = {pcPlus4[31:28], slot0_q[25:0], 2'b00};
    assign ownRedirect = jump | (branch & (zero ^ bne));
    assign ownTarget   = jump ? jTgt : brTgt;

    // With a delay slot the redirect taken on this accept is the one saved
    // from the previous instruction; the delay-slot word's own control is ignored.
`ifdef BRANCH_DELAY_SLOT_EN
    assign redirect = pendValid_q;
    assign target   = pendTgt_q;
`else
    assign redirect = ownRedirect;
    assign target   = ownTarget;
`endif

    // Request generation. imem_addr is always fetch_pc: in DRAIN fetch_pc still
    // holds the abandoned address and the redirect target waits in drainTgt_q.
    always_comb begin
        reqRaw = 1'b0;
        case (state_q)
            FETCH:   reqRaw = 1'b1;
            VALID:   reqRaw = ~slot1Valid_q;
            DRAIN:   reqRaw = 1'b1;
            default: reqRaw = 1'b0;
        endcase
    end

    assign imem_req    = reqRaw & ~rst;
    assign imem_addr   = fetchPc_q;
    assign xfer        = imem_req & imem_ack;
    assign instr_valid = (state_q == VALID) & ~rst;
    assign accept      = instr_valid & instr_ready;
    assign instr       = slot0_q;
    assign opcode      = slot0_q[31:26];
    assign pc_out      = pc0_q;

    // Next-state logic for slots, fetch PC and the fetch FSM.
    always_comb begin
        state_d      = state_q;
        fetchPc_d    = fetchPc_q;
        slot0_d      = slot0_q;
        pc0_d        = pc0_q;
        slot1_d      = slot1_q;
        slot1Valid_d = slot1Valid_q;
        drainTgt_d   = drainTgt_q;
`ifdef BRANCH_DELAY_SLOT_EN
        pendValid_d  = pendValid_q;
        pendTgt_d    = pendTgt_q;
        if (accept) begin
            if (pendValid_q) begin
                pendValid_d = 1'b0;
            end else if (ownRedirect) begin
                pendValid_d = 1'b1;
                pendTgt_d   = ownTarget;
            end
        end
`endif
        case (state_q)
            FETCH: begin
                if (xfer) begin
                    slot0_d   = imem_rdata;
                    pc0_d     = fetchPc_q;
                    fetchPc_d = fetchPc_q + 32'd4;
                    state_d   = VALID;
                end
            end
            VALID: begin
                if (!accept) begin
                    if (xfer) begin
                        slot1_d      = imem_rdata;
                        slot1Valid_d = 1'b1;
                        fetchPc_d    = fetchPc_q + 32'd4;
                    end
                end else if (redirect) begin
                    // A prefetch still in flight must complete before the
                    // target can be requested; a word acked now is dropped.
                    slot1Valid_d = 1'b0;
                    if (imem_req && !imem_ack) begin
                        drainTgt_d = target;
                        state_d    = DRAIN;
                    end else begin
                        fetchPc_d = target;
                        state_d   = FETCH;
                    end
                end else if (slot1Valid_q) begin
                    // slot1 always holds the word at pc+4.
                    slot0_d      = slot1_q;
                    pc0_d        = pcPlus4;
                    slot1Valid_d = 1'b0;
                end else if (xfer) begin
                    slot0_d   = imem_rdata;
                    pc0_d     = fetchPc_q;
                    fetchPc_d = fetchPc_q + 32'd4;
                end else begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    fetchPc_d = drainTgt_q;
                    state_d   = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State registers with synchronous reset; an outstanding request is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            fetchPc_q    <= RESET_PC;
            slot0_q      <= 32'd0;
            pc0_q        <= RESET_PC;
            slot1_q      <= 32'd0;
            slot1Valid_q <= 1'b0;
            drainTgt_q   <= RESET_PC;
`ifdef BRANCH_DELAY_SLOT_EN
            pendValid_q  <= 1'b0;
            pendTgt_q    <= RESET_PC;
`endif
        end else begin
            state_q      <= state_d;
            fetchPc_q    <= fetchPc_d;
            slot0_q      <= slot0_d;
            pc0_q        <= pc0_d;
            slot1_q      <= slot1_d;
            slot1Valid_q <= slot1Valid_d;
            drainTgt_q   <= drainTgt_d;
`ifdef BRANCH_DELAY_SLOT_EN
            pendValid_q  <= pendValid_d;
            pendTgt_q    <= pendTgt_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A memory responder and a downstream
// consumer are driven once per cycle from stepCycle; memory contents and the
// branch/jump control of every address come from bench-side functions. The
// expected stream of accepted PCs is produced by walking the program with the
// branch/jump rules directly (optionally with a delay slot when
// BRANCH_DELAY_SLOT_EN is defined).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        branch = 1'b0;
    logic        bne = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .pc_out(pc_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch(branch), .bne(bne), .zero(zero), .jump(jump)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Program overrides and per-address control {jump, branch, bne, zero}.
    logic [31:0] progOvr[logic [31:0]];
    logic [3:0]  ctrlOvr[logic [31:0]];
    bit          randCtrl = 1'b0;
    logic [31:0] ctrlSeed = 32'd0;

    int          ackPct = 100;
    int          readyPct = 100;
    bit          forceNotReady = 1'b0;
    logic [31:0] stallAddr = 32'd0;
    int          stallCnt = 0;

    logic [31:0] accPc[$];
    logic [31:0] accInstr[$];
    logic [31:0] fetched[$];
    logic [31:0] expPc[$];
    int          protoErr = 0;
    int          holdErr = 0;
    bit          prevPending = 1'b0;
    logic [31:0] prevAddr = 32'd0;
    bit          prevStall = 1'b0;
    logic [31:0] prevPc = 32'd0;
    logic [31:0] prevInstr = 32'd0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (progOvr.exists(a)) return progOvr[a];
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    function automatic logic [3:0] ctrlOf(input logic [31:0] a);
        logic [31:0] h;
        if (ctrlOvr.exists(a)) return ctrlOvr[a];
        if (!randCtrl) return 4'b0000;
        h = (a ^ ctrlSeed) * 32'h85EB_CA6B;
        h = h ^ (h >> 13);
        return {h[31:28] == 4'h0, h[27:26] == 2'b00, h[5], h[9]};
    endfunction

    function automatic int indexOf(input bit inFetched, input logic [31:0] v);
        if (inFetched) begin
            for (int i = 0; i < fetched.size(); i++) if (fetched[i] == v) return i;
        end else begin
            for (int i = 0; i < accPc.size(); i++) if (accPc[i] == v) return i;
        end
        return -1;
    endfunction

    // Program-order walk: each instruction goes to pc+4 unless its jump or
    // taken branch sends it elsewhere (one instruction later with a delay slot).
    task automatic modelSeq(input logic [31:0] start, input int n);
        logic [31:0] pc, w, p4, off, tgt, nxt, pendTgt;
        logic [3:0]  c;
        bit          redir, taken, pend;
        expPc.delete();
        pc = start;
        pend = 1'b0;
        pendTgt = 32'd0;
        for (int i = 0; i < n; i++) begin
            expPc.push_back(pc);
            w = memWord(pc);
            c = ctrlOf(pc);
            p4 = pc + 32'd4;
            taken = c[2] && (c[1] ? !c[0] : c[0]);
            redir = c[3] || taken;
            off = {{16{w[15]}}, w[15:0]};
            if (c[3]) tgt = {p4[31:28], w[25:0], 2'b00};
            else      tgt = p4 + off * 32'd4;
`ifdef BRANCH_DELAY_SLOT_EN
            if (pend) begin
                nxt = pendTgt;
                pend = 1'b0;
            end else if (redir) begin
                pend = 1'b1;
                pendTgt = tgt;
                nxt = p4;
            end else begin
                nxt = p4;
            end
`else
            nxt = redir ? tgt : p4;
`endif
            pc = nxt;
        end
    endtask

    // One clock of environment behaviour: memory responder, consumer and
    // control inputs, plus logging of completed handshakes.
    task automatic stepCycle();
        logic [3:0] c;
        bit ack, rdy;
        #1;
        if (!rst) begin
            if (prevPending && (!imem_req || imem_addr !== prevAddr)) protoErr++;
            if (prevStall && (!instr_valid || pc_out !== prevPc || instr !== prevInstr)) holdErr++;
        end
        c = ctrlOf(pc_out);
        {jump, branch, bne, zero} = c;
        ack = ($urandom_range(99) < ackPct);
        if (stallCnt > 0 && imem_req && imem_addr == stallAddr) begin
            ack = 1'b0;
            stallCnt--;
        end
        rdy = !forceNotReady && ($urandom_range(99) < readyPct);
        imem_ack = ack;
        instr_ready = rdy;
        imem_rdata = ack ? memWord(imem_addr) : 32'hDEAD_BEEF;
        if (!rst) begin
            if (instr_valid && rdy) begin
                accPc.push_back(pc_out);
                accInstr.push_back(instr);
            end
            if (imem_req && ack) fetched.push_back(imem_addr);
        end
        prevPending = !rst && imem_req && !ack;
        prevAddr = imem_addr;
        prevStall = !rst && instr_valid && !rdy;
        prevPc = pc_out;
        prevInstr = instr;
        @(negedge clk);
    endtask

    task automatic clearLogs();
        accPc.delete();
        accInstr.delete();
        fetched.delete();
        protoErr = 0;
        holdErr = 0;
        prevPending = 1'b0;
        prevStall = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) stepCycle();
        rst = 1'b0;
        clearLogs();
    endtask

    task automatic setEnv(input bit rc, input int ap, input int rp);
        progOvr.delete();
        ctrlOvr.delete();
        randCtrl = rc;
        ackPct = ap;
        readyPct = rp;
        forceNotReady = 1'b0;
        stallCnt = 0;
    endtask

    task automatic test_reset();
        setEnv(0, 100, 100);
        rst = 1'b1;
        repeat (3) stepCycle();
        #1;
        nChecks++; if (imem_req !== 1'b0) begin nFails++; $display("FAIL reset_req: got %b want 0", imem_req); end
        nChecks++; if (imem_addr !== RPC) begin nFails++; $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); end
        nChecks++; if (instr !== 32'd0) begin nFails++; $display("FAIL reset_instr: got %h want 0", instr); end
        nChecks++; if (opcode !== 6'd0) begin nFails++; $display("FAIL reset_opcode: got %h want 0", opcode); end
        nChecks++; if (pc_out !== RPC) begin nFails++; $display("FAIL reset_pc: got %h want %h", pc_out, RPC); end
        nChecks++; if (instr_valid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        rst = 1'b0;
        clearLogs();
    endtask

    task automatic test_sequential();
        logic [31:0] w, expPcK;
        setEnv(0, 100, 100);
        doReset();
        for (int k = 0; k < 20; k++) begin
            #1;
            expPcK = RPC + 32'(4 * (k - 1));
            w = memWord(expPcK);
            if (k == 0) begin
                nChecks++;
                if (imem_req !== 1'b1 || imem_addr !== RPC || instr_valid !== 1'b0) begin
                    nFails++;
                    $display("FAIL seq_first: req=%b addr=%h valid=%b want 1 %h 0", imem_req, imem_addr, instr_valid, RPC);
                end
            end else if (k < 10) begin
                nChecks++;
                if (instr_valid !== 1'b1 || pc_out !== expPcK || opcode !== w[31:26] || imem_addr !== expPcK + 32'd4) begin
                    nFails++;
                    $display("FAIL seq_cycle%0d: valid=%b pc=%h op=%h addr=%h want 1 %h %h %h",
                             k, instr_valid, pc_out, opcode, imem_addr, expPcK, w[31:26], expPcK + 32'd4);
                end
            end
            stepCycle();
        end
        nChecks++;
        if (accPc.size() != 19) begin nFails++; $display("FAIL back_to_back_count: got %0d want 19", accPc.size()); end
    endtask

    task automatic test_branch();
        int i, bad;
        setEnv(0, 100, 100);
        progOvr[RPC] = {6'h02, 26'h000_0004};
        ctrlOvr[RPC] = 4'b1000;
        progOvr[32'h10] = {6'h04, 5'd1, 5'd2, 16'h0003};
        ctrlOvr[32'h10] = 4'b0101;
        doReset();
        repeat (30) stepCycle();
        i = indexOf(0, 32'h10);
        nChecks++;
`ifdef BRANCH_DELAY_SLOT_EN
        if (i < 0 || i + 2 >= accPc.size() || accPc[i + 1] !== 32'h14 || accPc[i + 2] !== 32'h20) begin
            nFails++; $display("FAIL delay_slot_seq: index %0d of 0x10 in %0d accepts", i, accPc.size());
        end
`else
        if (i < 0 || i + 1 >= accPc.size() || accPc[i + 1] !== 32'h20) begin
            nFails++; $display("FAIL beq_target: index %0d of 0x10 in %0d accepts, want next 0x20", i, accPc.size());
        end
        nChecks++;
        if (indexOf(0, 32'h14) != -1) begin nFails++; $display("FAIL beq_squash: 0x14 accepted at %0d want never", indexOf(0, 32'h14)); end
`endif
        modelSeq(RPC, accPc.size());
        bad = 0;
        for (int k = 0; k < accPc.size(); k++) if (accPc[k] !== expPc[k] || accInstr[k] !== memWord(expPc[k])) bad++;
        nChecks++;
        if (bad != 0) begin nFails++; $display("FAIL beq_stream: %0d mismatching accepts, want 0", bad); end

        setEnv(0, 100, 100);
        progOvr[RPC] = {6'h02, 26'h000_0004};
        ctrlOvr[RPC] = 4'b1000;
        progOvr[32'h10] = {6'h05, 5'd1, 5'd2, 16'h0003};
        ctrlOvr[32'h10] = 4'b0111;
        progOvr[32'h20] = {6'h02, 26'h000_0100};
        ctrlOvr[32'h20] = 4'b1000;
        doReset();
        repeat (30) stepCycle();
        i = indexOf(0, 32'h10);
        nChecks++;
        if (i < 0 || i + 1 >= accPc.size() || accPc[i + 1] !== 32'h14) begin
            nFails++; $display("FAIL bne_not_taken: index %0d of 0x10, want next 0x14", i);
        end
        i = indexOf(0, 32'h20);
        nChecks++;
`ifdef BRANCH_DELAY_SLOT_EN
        if (i < 0 || i + 2 >= accPc.size() || accPc[i + 2] !== 32'h400) begin
`else
        if (i < 0 || i + 1 >= accPc.size() || accPc[i + 1] !== 32'h400) begin
`endif
            nFails++; $display("FAIL jump_target: index %0d of 0x20 in %0d accepts, want 0x400 next", i, accPc.size());
        end
        modelSeq(RPC, accPc.size());
        bad = 0;
        for (int k = 0; k < accPc.size(); k++) if (accPc[k] !== expPc[k] || accInstr[k] !== memWord(expPc[k])) bad++;
        nChecks++;
        if (bad != 0) begin nFails++; $display("FAIL bne_jump_stream: %0d mismatching accepts, want 0", bad); end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, in0;
        int f0, bad;
        setEnv(0, 100, 100);
        doReset();
        repeat (6) stepCycle();
        #1;
        pc0 = pc_out;
        in0 = instr;
        f0 = fetched.size();
        forceNotReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            #1;
            nChecks++;
            if (instr_valid !== 1'b1 || pc_out !== pc0 || instr !== in0) begin
                nFails++; $display("FAIL stall_hold%0d: valid=%b pc=%h instr=%h want 1 %h %h", k, instr_valid, pc_out, instr, pc0, in0);
            end
        end
        nChecks++;
        if (fetched.size() - f0 != 1) begin nFails++; $display("FAIL stall_prefetch: got %0d fetches want 1", fetched.size() - f0); end
        forceNotReady = 1'b0;
        repeat (10) stepCycle();
        modelSeq(RPC, accPc.size());
        bad = 0;
        for (int k = 0; k < accPc.size(); k++) if (accPc[k] !== expPc[k] || accInstr[k] !== memWord(expPc[k])) bad++;
        nChecks++;
        if (bad != 0 || accPc.size() < 12) begin nFails++; $display("FAIL stall_resume: %0d mismatches in %0d accepts", bad, accPc.size()); end
    endtask

    task automatic test_drain();
        logic [31:0] sAddr, redirPc;
        int i, n, bad, guard;
`ifdef BRANCH_DELAY_SLOT_EN
        sAddr = 32'h18;
        redirPc = 32'h14;
`else
        sAddr = 32'h14;
        redirPc = 32'h10;
`endif
        setEnv(0, 100, 100);
        progOvr[RPC] = {6'h02, 26'h000_0004};
        ctrlOvr[RPC] = 4'b1000;
        progOvr[32'h10] = {6'h04, 5'd1, 5'd2, 16'h0003};
        ctrlOvr[32'h10] = 4'b0101;
        doReset();
        stallAddr = sAddr;
        stallCnt = 3;
        repeat (25) stepCycle();
        nChecks++;
        if (protoErr != 0) begin nFails++; $display("FAIL drain_hold: %0d request withdrawals want 0", protoErr); end
        nChecks++;
        if (stallCnt != 0) begin nFails++; $display("FAIL drain_reached: %0d stall cycles unused want 0", stallCnt); end
        n = 0;
        foreach (fetched[k]) if (fetched[k] == sAddr) n++;
        i = indexOf(1, sAddr);
        nChecks++;
        if (n != 1 || i < 0 || i + 1 >= fetched.size() || fetched[i + 1] !== 32'h20) begin
            nFails++; $display("FAIL drain_next_req: %h fetched %0d times at %0d want once then 0x20", sAddr, n, i);
        end
        nChecks++;
        if (indexOf(0, sAddr) != -1) begin nFails++; $display("FAIL drain_discard: %h accepted want never", sAddr); end
        modelSeq(RPC, accPc.size());
        bad = 0;
        for (int k = 0; k < accPc.size(); k++) if (accPc[k] !== expPc[k] || accInstr[k] !== memWord(expPc[k])) bad++;
        nChecks++;
        if (bad != 0) begin nFails++; $display("FAIL drain_stream: %0d mismatching accepts want 0", bad); end

        // Reset arriving while a drain is still waiting for its ack.
        doReset();
        stallAddr = sAddr;
        stallCnt = 50;
        guard = 0;
        while (indexOf(0, redirPc) < 0 && guard < 40) begin
            stepCycle();
            guard++;
        end
        nChecks++;
        if (guard >= 40) begin nFails++; $display("FAIL drain_setup: redirect at %h not accepted within 40 cycles", redirPc); end
        repeat (2) stepCycle();
        rst = 1'b1;
        stepCycle();
        #1;
        nChecks++;
        if (imem_req !== 1'b0 || imem_addr !== RPC || instr !== 32'd0 || opcode !== 6'd0 || pc_out !== RPC || instr_valid !== 1'b0) begin
            nFails++;
            $display("FAIL drain_reset_outputs: req=%b addr=%h instr=%h op=%h pc=%h valid=%b want 0 %h 0 0 %h 0",
                     imem_req, imem_addr, instr, opcode, pc_out, instr_valid, RPC, RPC);
        end
        rst = 1'b0;
        stallCnt = 0;
        clearLogs();
        #1;
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            nFails++; $display("FAIL drain_reset_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC);
        end
        repeat (6) stepCycle();
        nChecks++;
        if (accPc.size() == 0 || accPc[0] !== RPC) begin nFails++; $display("FAIL drain_reset_resume: %0d accepts, want first at %h", accPc.size(), RPC); end
    endtask

    task automatic test_wrap();
        int i, bad;
        setEnv(0, 100, 100);
        progOvr[RPC] = {6'h02, 26'h000_0000};
        ctrlOvr[RPC] = 4'b1000;
        progOvr[32'h0] = {6'h04, 5'd0, 5'd0, 16'hFFFE};
        ctrlOvr[32'h0] = 4'b0101;
        doReset();
        repeat (20) stepCycle();
        i = indexOf(0, 32'hFFFF_FFFC);
        nChecks++;
        if (i < 0 || i + 1 >= accPc.size() || accPc[i + 1] !== 32'h0) begin
            nFails++; $display("FAIL pc_wrap: index %0d of FFFFFFFC in %0d accepts, want next 0", i, accPc.size());
        end
        modelSeq(RPC, accPc.size());
        bad = 0;
        for (int k = 0; k < accPc.size(); k++) if (accPc[k] !== expPc[k] || accInstr[k] !== memWord(expPc[k])) bad++;
        nChecks++;
        if (bad != 0) begin nFails++; $display("FAIL wrap_stream: %0d mismatching accepts want 0", bad); end
    endtask

    task automatic test_random();
        int bad;
        for (int r = 0; r < 3; r++) begin
            setEnv(1, 55 + 20 * r, 60 + 15 * r);
            ctrlSeed = $urandom;
            doReset();
            repeat (600) stepCycle();
            modelSeq(RPC, accPc.size());
            bad = 0;
            for (int k = 0; k < accPc.size(); k++) if (accPc[k] !== expPc[k] || accInstr[k] !== memWord(expPc[k])) bad++;
            nChecks++;
            if (bad != 0 || accPc.size() < 50) begin
                nFails++; $display("FAIL rand_stream%0d: %0d mismatches in %0d accepts", r, bad, accPc.size());
            end
            nChecks++;
            if (protoErr != 0 || holdErr != 0) begin
                nFails++; $display("FAIL rand_protocol%0d: withdrawals=%0d hold_errors=%0d want 0 0", r, protoErr, holdErr);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_drain();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
